// File: rtl/navibot_pwm_multi.sv
// navibot_pwm_multi: N-channel motor PWM and turn-signal blinker generator.
// A prescaler produces a PWM tick. Each tick advances a shared PWM counter and
// a free-running blink counter. Each channel latches its duty at period start.
// Dropping a channel's run request stops that channel at once.
// Optional soft-start ramp: define NAVIBOT_SOFTSTART_EN.
module navibot_pwm_multi #(
   parameter int NUM_CH     = 2,
   parameter int PWM_W      = 8,
   parameter int PRESC      = 12500,
   parameter int BLINK_HALF = 2000,
   parameter int RAMP_DIV   = 4
) (
   input  logic                      clk_in,
   input  logic                      rst,
   input  logic [PWM_W-1:0]          speed_set,
   input  logic                      slow0_fast1,
   input  logic [NUM_CH-1:0]         mtr_ctrl,
   input  logic [NUM_CH-1:0]         led_en,
   output logic [NUM_CH-1:0]         mtr_en,
   output logic [NUM_CH-1:0]         blinker,
   output logic [NUM_CH*PWM_W-1:0]   duty_mon,
   output logic                      pwm_tick
);

   localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
`ifdef NAVIBOT_SOFTSTART_EN
   localparam int STEP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } ch_state_t;

   logic [PRESC_W-1:0] presc_reg;
   logic               pwm_tick_reg;
   logic [PWM_W-1:0]   pwm_cnt_reg;
   logic [BLINK_W-1:0] blink_cnt_reg;
   logic               blink_phase_reg;
   logic [NUM_CH-1:0]  blinker_reg;
   logic [PWM_W-1:0]   speed_eff;
   logic               period_start;

   // Slow mode halves the requested speed for every channel.
   assign speed_eff    = slow0_fast1 ? speed_set : (speed_set >> 1);
   // The tick that wraps the PWM counter back to zero opens a new period.
   assign period_start = pwm_tick_reg && (pwm_cnt_reg == {PWM_W{1'b1}});
   assign pwm_tick     = pwm_tick_reg;
   assign blinker      = blinker_reg;

   // Prescaler: the tick pulse is high for the cycle after the count reaches PRESC-1.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         presc_reg    <= '0;
         pwm_tick_reg <= 1'b0;
      end else begin
         pwm_tick_reg <= (presc_reg == PRESC_W'(PRESC - 1));
         if (presc_reg == PRESC_W'(PRESC - 1))
            presc_reg <= '0;
         else
            presc_reg <= presc_reg + PRESC_W'(1);
      end
   end

   // Shared PWM counter advances once per tick and wraps naturally.
   always_ff @(posedge clk_in) begin
      if (rst)
         pwm_cnt_reg <= '0;
      else if (pwm_tick_reg)
         pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
   end

   // Free-running blink timebase: phase flips every BLINK_HALF ticks.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
      end else if (pwm_tick_reg) begin
         if (blink_cnt_reg == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
         end
      end
   end

   // Blinker outputs: gated phase, so clearing an enable drops the output on the next edge.
   always_ff @(posedge clk_in) begin
      if (rst)
         blinker_reg <= '0;
      else
         blinker_reg <= led_en & {NUM_CH{blink_phase_reg}};
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t        state_reg, state_next;
      logic [PWM_W-1:0] duty_reg, duty_next, tgt;
      logic             mtr_en_bit_reg;
`ifdef NAVIBOT_SOFTSTART_EN
      logic [STEP_W-1:0] step_reg, step_next;
      logic              step_due;
      assign step_due = (step_reg == '0);
`endif

      assign tgt                          = mtr_ctrl[gi] ? speed_eff : '0;
      assign mtr_en[gi]                   = mtr_en_bit_reg;
      assign duty_mon[gi*PWM_W +: PWM_W]  = duty_reg;

      // Duty and channel state: stop overrides everything, otherwise load at period start.
      always_comb begin
         state_next = state_reg;
         duty_next  = duty_reg;
`ifdef NAVIBOT_SOFTSTART_EN
         step_next  = step_reg;
`endif
         if (!mtr_ctrl[gi]) begin
            duty_next = '0;
         end else if (period_start) begin
`ifdef NAVIBOT_SOFTSTART_EN
            if (tgt > duty_reg)
               duty_next = duty_reg + PWM_W'(step_due);
            else
               duty_next = tgt;
            step_next = (step_reg == STEP_W'(RAMP_DIV - 1)) ? '0 : step_reg + STEP_W'(1);
`else
            duty_next = tgt;
`endif
         end
         if (!mtr_ctrl[gi] || ((duty_next == '0) && (tgt == '0)))
            state_next = ST_IDLE;
         else if (duty_next < tgt)
            state_next = ST_RAMP;
         else
            state_next = ST_HOLD;
`ifdef NAVIBOT_SOFTSTART_EN
         if (state_next == ST_IDLE)
            step_next = '0;
`endif
      end

      // Channel registers and active-low driver enable (strict compare against duty).
      always_ff @(posedge clk_in) begin
         if (rst) begin
            state_reg      <= ST_IDLE;
            duty_reg       <= '0;
            mtr_en_bit_reg <= 1'b1;
         end else begin
            state_reg      <= state_next;
            duty_reg       <= duty_next;
            mtr_en_bit_reg <= ~((state_reg != ST_IDLE) && (pwm_cnt_reg < duty_reg));
         end
      end

`ifdef NAVIBOT_SOFTSTART_EN
      // Soft-start step counter: one duty increment every RAMP_DIV periods.
      always_ff @(posedge clk_in) begin
         if (rst)
            step_reg <= '0;
         else
            step_reg <= step_next;
      end
`endif
   end

endmodule

// File: tb/tb_navibot_pwm_multi.sv
// Testbench for navibot_pwm_multi.
// A stimulus process pushes per-cycle expectations from an arithmetic reference
// model. A monitor process pops and compares them on the falling edge.
module tb_navibot_pwm_multi;

   localparam int NUM_CH     = 2;
   localparam int PWM_W      = 4;
   localparam int PRESC      = 4;
   localparam int BLINK_HALF = 3;
   localparam int RAMP_DIV   = 2;
   localparam int PERIOD_CLK = PRESC * 16;

   logic                    clk_in = 1'b0;
   logic                    rst;
   logic [PWM_W-1:0]        speed_set;
   logic                    slow0_fast1;
   logic [NUM_CH-1:0]       mtr_ctrl;
   logic [NUM_CH-1:0]       led_en;
   logic [NUM_CH-1:0]       mtr_en;
   logic [NUM_CH-1:0]       blinker;
   logic [NUM_CH*PWM_W-1:0] duty_mon;
   logic                    pwm_tick;

   always #5 clk_in = ~clk_in;

   navibot_pwm_multi #(
      .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC(PRESC),
      .BLINK_HALF(BLINK_HALF), .RAMP_DIV(RAMP_DIV)
   ) dut (
      .clk_in(clk_in), .rst(rst), .speed_set(speed_set), .slow0_fast1(slow0_fast1),
      .mtr_ctrl(mtr_ctrl), .led_en(led_en), .mtr_en(mtr_en), .blinker(blinker),
      .duty_mon(duty_mon), .pwm_tick(pwm_tick)
   );

   typedef struct {
      int                      cyc;
      logic [NUM_CH-1:0]       mtr_en;
      logic [NUM_CH-1:0]       blinker;
      logic [NUM_CH*PWM_W-1:0] duty_mon;
      logic                    tick;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: edges since reset release and per-channel duty.
   int e_m = 0;
   int duty_m[NUM_CH];
`ifdef NAVIBOT_SOFTSTART_EN
   int step_m[NUM_CH];
`endif

   always @(posedge clk_in) cyc <= cyc + 1;

   // Number of PWM ticks that have advanced the counters after edge e.
   function automatic int ticks_f(int e);
      if (e <= 0) return 0;
      return (e - 1) / PRESC;
   endfunction

   function automatic int cnt_f(int e);
      return ticks_f(e) % 16;
   endfunction

   function automatic int phase_f(int e);
      return (ticks_f(e) / BLINK_HALF) % 2;
   endfunction

   function automatic bit is_ps(int e);
      return (e >= 1) && (ticks_f(e) > ticks_f(e - 1)) && (cnt_f(e) == 0);
   endfunction

   // One clock: predict outputs after the coming edge, queue them, then advance.
   task automatic cycle();
      exp_t x;
      bit   ps;
      int   tgt;
      x.cyc = cyc + 1;
      if (rst) begin
         e_m = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_m[i] = 0;
`ifdef NAVIBOT_SOFTSTART_EN
            step_m[i] = 0;
`endif
         end
         x.mtr_en   = '1;
         x.blinker  = '0;
         x.duty_mon = '0;
         x.tick     = 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            x.mtr_en[i]  = (cnt_f(e_m) < duty_m[i]) ? 1'b0 : 1'b1;
            x.blinker[i] = led_en[i] && (phase_f(e_m) == 1);
         end
         e_m = e_m + 1;
         ps  = is_ps(e_m);
         for (int i = 0; i < NUM_CH; i++) begin
            tgt = mtr_ctrl[i] ? (slow0_fast1 ? int'(speed_set) : int'(speed_set) / 2) : 0;
            if (!mtr_ctrl[i]) begin
               duty_m[i] = 0;
            end else if (ps) begin
`ifdef NAVIBOT_SOFTSTART_EN
               if (tgt > duty_m[i]) begin
                  if (step_m[i] == 0) duty_m[i] = duty_m[i] + 1;
               end else begin
                  duty_m[i] = tgt;
               end
               step_m[i] = (step_m[i] + 1) % RAMP_DIV;
`else
               duty_m[i] = tgt;
`endif
            end
`ifdef NAVIBOT_SOFTSTART_EN
            if (!mtr_ctrl[i] || (duty_m[i] == 0 && tgt == 0)) step_m[i] = 0;
`endif
            x.duty_mon[i*PWM_W +: PWM_W] = PWM_W'(duty_m[i]);
         end
         x.tick = ((e_m % PRESC) == 0);
      end
      exp_q.push_back(x);
      @(negedge clk_in);
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   // Advance until the next edge is a period start.
   task automatic run_to_ps();
      int g = 0;
      while (!is_ps(e_m + 1) && g < 200) begin
         cycle();
         g++;
      end
      if (g >= 200) begin
         checks++;
         errors++;
         $display("FAIL run_to_ps timeout got=%0d cycles required<200", g);
      end
   endtask

   // Advance until the PWM counter holds value c.
   task automatic run_to_cnt(int c);
      int g = 0;
      while (cnt_f(e_m) != c && g < 200) begin
         cycle();
         g++;
      end
      if (g >= 200) begin
         checks++;
         errors++;
         $display("FAIL run_to_cnt timeout got=%0d cycles required<200", g);
      end
   endtask

   // Monitor: compare every registered output against the queued prediction.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk_in);
         if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            x = exp_q.pop_front();
            if (x.cyc != cyc) begin
               checks++;
               errors++;
               $display("FAIL sequence got_cyc=%0d required_cyc=%0d", cyc, x.cyc);
            end else begin
               $display("cyc=%0d mtr_en=%b blinker=%b duty_mon=%h tick=%b", cyc, mtr_en, blinker, duty_mon, pwm_tick);
               checks++;
               if (mtr_en !== x.mtr_en) begin
                  errors++;
                  $display("FAIL mtr_en cyc=%0d got=%b required=%b", cyc, mtr_en, x.mtr_en);
               end
               checks++;
               if (blinker !== x.blinker) begin
                  errors++;
                  $display("FAIL blinker cyc=%0d got=%b required=%b", cyc, blinker, x.blinker);
               end
               checks++;
               if (duty_mon !== x.duty_mon) begin
                  errors++;
                  $display("FAIL duty_mon cyc=%0d got=%h required=%h", cyc, duty_mon, x.duty_mon);
               end
               checks++;
               if (pwm_tick !== x.tick) begin
                  errors++;
                  $display("FAIL pwm_tick cyc=%0d got=%b required=%b", cyc, pwm_tick, x.tick);
               end
            end
         end
      end
   end

   // Watchdog against a stalled run.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; speed_set = '0; slow0_fast1 = 1'b1; mtr_ctrl = '0; led_en = '0;
      run(3);
      rst = 1'b0;
      run(10);
      // Fast mode, channel 0 only, duty 8.
      speed_set = 4'd8; slow0_fast1 = 1'b1; mtr_ctrl = 2'b01;
      run(3 * PERIOD_CLK);
      // Reset mid-run with both channels requested.
      mtr_ctrl = 2'b11;
      run(40);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(150);
      // Slow mode: 9 >> 1 = 4.
      mtr_ctrl = 2'b01; speed_set = 4'd9; slow0_fast1 = 1'b0;
      run(2 * PERIOD_CLK + 10);
      // Mid-period speed change only applies at the next period.
      speed_set = 4'd8; slow0_fast1 = 1'b1;
      run_to_ps();
      run(1);
      run_to_cnt(5);
      speed_set = 4'd12;
      run(2 * PERIOD_CLK);
      // Safety stop mid-period.
      run_to_cnt(3);
      mtr_ctrl = 2'b00;
      run(8);
      mtr_ctrl = 2'b01;
      run(70);
      // Maximum duty, then a zero target while still requested.
      speed_set = 4'd15; mtr_ctrl = 2'b11;
      run(2 * PERIOD_CLK + 4);
      speed_set = 4'd1; slow0_fast1 = 1'b0;
      run(70);
      // Stop coinciding with a period start.
      speed_set = 4'd10; slow0_fast1 = 1'b1; mtr_ctrl = 2'b01;
      run(70);
      run_to_ps();
      mtr_ctrl = 2'b00;
      cycle();
      run(5);
      // Target 3 from idle, then cut to 1.
      speed_set = 4'd3; mtr_ctrl = 2'b01;
      run(7 * PERIOD_CLK);
      speed_set = 4'd1;
      run(2 * PERIOD_CLK);
      // Blinker on channel 1, cleared while high.
      led_en = 2'b10;
      run(30);
      while (phase_f(e_m) != 1) cycle();
      run(2);
      led_en = 2'b00;
      run(20);
      led_en = 2'b11;
      run(40);
      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(15, 0) == 0) speed_set = PWM_W'($urandom);
         if ($urandom_range(23, 0) == 0) slow0_fast1 = ~slow0_fast1;
         if ($urandom_range(19, 0) == 0) mtr_ctrl = NUM_CH'($urandom);
         if ($urandom_range(19, 0) == 0) led_en = NUM_CH'($urandom);
         rst = ($urandom_range(399, 0) == 0);
         cycle();
      end
      rst = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
